// File: rtl/lpif_tx_quarter_pack_ctrl_if.sv
// Beat-in / FIFO-word-out bundle for the quarter-rate LPIF TX packing controller.
// The controller uses the slave view; the beat source and FIFO model use the master view.
interface lpif_tx_quarter_pack_ctrl_if #(
    parameter int BEAT_W    = 281,
    parameter int NUM_SLOTS = 4,
    parameter int CNT_W     = 16
);
    logic                          m_gen2_mode;
    logic                          beat_valid;
    logic                          beat_ready;
    logic [BEAT_W-1:0]             beat_data;
    logic                          flush_req;
    logic                          txfifo_full;
    logic                          txfifo_push;
    logic [NUM_SLOTS*BEAT_W-1:0]   txfifo_downstream_data;
    logic                          busy;
    logic [CNT_W-1:0]              word_cnt;

    modport master (
        output m_gen2_mode, beat_valid, beat_data, flush_req, txfifo_full,
        input  beat_ready, txfifo_push, txfifo_downstream_data, busy, word_cnt
    );

    modport slave (
        input  m_gen2_mode, beat_valid, beat_data, flush_req, txfifo_full,
        output beat_ready, txfifo_push, txfifo_downstream_data, busy, word_cnt
    );
endinterface

// File: rtl/lpif_tx_quarter_pack_ctrl.sv
// Packs full-rate LPIF beats into slots of one quarter-rate TX FIFO word, with one pending
// word register so a completed word can wait out FIFO backpressure while staging refills.
//
//   state | meaning
//   EMPTY | slot_cnt=0, no pending word
//   FILL  | staging holds 1..last beats
//   PEND  | completed word waiting for / pushing into the FIFO
//   STALL | staging at last slot, pending word blocked by full FIFO: beat_ready=0
module lpif_tx_quarter_pack_ctrl #(
    parameter int BEAT_W       = 281,
    parameter int NUM_SLOTS    = 4,
    parameter int IDLE_TIMEOUT = 8,
    parameter int CNT_W        = 16
) (
    input  logic                         clk_wr,
    input  logic                         rst_wr_n,
    lpif_tx_quarter_pack_ctrl_if.slave   bus
);
    localparam int SLOT_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = (IDLE_TIMEOUT > 0) ? IDLE_W'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [SLOT_W-1:0] LAST_GEN2 = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] LAST_GEN1 = SLOT_W'(NUM_SLOTS / 2 - 1);

    logic [NUM_SLOTS-1:0][BEAT_W-1:0] stage_q, stage_d, stage_ins;
    logic [SLOT_W-1:0]                slot_cnt_q, slot_cnt_d;
    logic                             pend_vld_q, pend_vld_d;
    logic [NUM_SLOTS*BEAT_W-1:0]      pend_data_q, pend_data_d;
    logic [IDLE_W-1:0]                idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]                 word_cnt_q, word_cnt_d;

    logic [SLOT_W-1:0] last;
    logic              push, pend_free, ready, accept, timeout_hit, complete;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            stage_q     <= '0;
            slot_cnt_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            idle_cnt_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            stage_q     <= stage_d;
            slot_cnt_q  <= slot_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            idle_cnt_q  <= idle_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    always_comb begin
        timeout_hit = (IDLE_TIMEOUT != 0) && (idle_cnt_q == IDLE_LAST)
                      && (slot_cnt_q != '0) && !accept;
        complete    = pend_free & ((accept & (slot_cnt_q == last))
                                   | (bus.flush_req & ((slot_cnt_q != '0) | accept))
                                   | timeout_hit);

        stage_ins = stage_q;
        if (accept) stage_ins[slot_cnt_q] = bus.beat_data;

        stage_d     = stage_ins;
        slot_cnt_d  = slot_cnt_q;
        pend_vld_d  = pend_vld_q & ~push;
        pend_data_d = pend_data_q;
        if (accept) slot_cnt_d = slot_cnt_q + 1'b1;
        // Completion wins over a same-cycle push: the freed register is refilled at once.
        if (complete) begin
            stage_d     = '0;
            slot_cnt_d  = '0;
            pend_vld_d  = 1'b1;
            pend_data_d = stage_ins;
        end

        idle_cnt_d = idle_cnt_q;
        if (accept || complete || (slot_cnt_q == '0)) idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_LAST)             idle_cnt_d = idle_cnt_q + 1'b1;

        word_cnt_d = word_cnt_q;
        if (push) word_cnt_d = word_cnt_q + 1'b1;
    end

    always_comb begin
        last      = bus.m_gen2_mode ? LAST_GEN2 : LAST_GEN1;
        push      = pend_vld_q & ~bus.txfifo_full;
        pend_free = ~pend_vld_q | push;
        ready     = rst_wr_n & ((slot_cnt_q != last) | pend_free);
        accept    = bus.beat_valid & ready;
    end

    assign bus.beat_ready             = ready;
    assign bus.txfifo_push            = push;
    assign bus.txfifo_downstream_data = pend_data_q;
    assign bus.busy                   = (slot_cnt_q != '0) | pend_vld_q;
    assign bus.word_cnt               = word_cnt_q;
endmodule

// File: tb/tb_lpif_tx_quarter_pack_ctrl.sv
// Randomized and directed bench for the LPIF TX quarter-rate packer against a queue-based
// model of staged beats and one pending word.
module tb_lpif_tx_quarter_pack_ctrl;
    localparam int BW = 281;
    localparam int NS = 4;
    localparam int TO = 8;
    localparam int CW = 16;
    localparam int WW = NS * BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lpif_tx_quarter_pack_ctrl_if #(.BEAT_W(BW), .NUM_SLOTS(NS), .CNT_W(CW)) bus ();

    lpif_tx_quarter_pack_ctrl #(.BEAT_W(BW), .NUM_SLOTS(NS), .IDLE_TIMEOUT(TO), .CNT_W(CW)) u_dut (
        .clk_wr   (clk),
        .rst_wr_n (rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state and its next value
    logic [BW-1:0] m_stage[$];
    logic          m_pv = 1'b0;
    logic [WW-1:0] m_pd = '0;
    int            m_idle = 0;
    int            m_wc = 0;
    logic [BW-1:0] n_stage[$];
    logic          n_pv;
    logic [WW-1:0] n_pd;
    int            n_idle;
    int            n_wc;
    bit            last_acc;
    bit            m_busy;

    logic [BW-1:0] ab[8];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        int diff;
        total++;
        if (act !== exp) begin
            bad++;
            diff = -1;
            for (int i = 0; i < WW; i++) if (diff < 0 && act[i] !== exp[i]) diff = i;
            $display("FAIL %s act_lo=%h exp_lo=%h first_diff_bit=%0d", name, act[63:0], exp[63:0], diff);
        end
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [287:0] t;
        logic [BW-1:0] b;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        b = t[BW-1:0];
        b[BW-1] = 1'b1;
        return b;
    endfunction

    function automatic logic [WW-1:0] pack(input logic [BW-1:0] q[$]);
        logic [WW-1:0] w;
        w = '0;
        foreach (q[k]) w[k*BW +: BW] = q[k];
        return w;
    endfunction

    // compare DUT against the model, then compute the model's next state from current inputs
    task automatic sample();
        int slots;
        bit e_push, pfree, e_ready, acc, comp;
        logic [BW-1:0] tmp[$];
        @(negedge clk);
        slots   = bus.m_gen2_mode ? NS : NS / 2;
        e_push  = m_pv && !bus.txfifo_full;
        pfree   = !m_pv || e_push;
        e_ready = rst_n && ((m_stage.size() != slots - 1) || pfree);
        check("beat_ready", WW'(bus.beat_ready), WW'(e_ready));
        check("txfifo_push", WW'(bus.txfifo_push), WW'(e_push));
        check("busy", WW'(bus.busy), WW'(m_stage.size() > 0 || m_pv));
        check("word_cnt", WW'(bus.word_cnt), WW'(m_wc % 65536));
        if (e_push) check("data", bus.txfifo_downstream_data, m_pd);
        acc = 0;
        if (!rst_n) begin
            n_stage = {};
            n_pv = 0; n_pd = '0; n_idle = 0; n_wc = 0;
        end else begin
            acc = bus.beat_valid && e_ready;
            tmp = m_stage;
            if (acc) tmp.push_back(bus.beat_data);
            comp = pfree && ((acc && m_stage.size() == slots - 1)
                          || (bus.flush_req && (m_stage.size() > 0 || acc))
                          || (TO != 0 && m_idle >= TO - 1 && m_stage.size() > 0 && !acc));
            if (comp) begin
                n_pd = pack(tmp); n_pv = 1; n_stage = {};
            end else begin
                n_pd = m_pd; n_pv = e_push ? 1'b0 : m_pv; n_stage = tmp;
            end
            n_idle = (acc || comp || m_stage.size() == 0) ? 0 : m_idle + 1;
            n_wc   = m_wc + (e_push ? 1 : 0);
        end
        last_acc = acc;
    endtask

    task automatic tick();
        @(posedge clk);
        m_stage = n_stage; m_pv = n_pv; m_pd = n_pd; m_idle = n_idle; m_wc = n_wc;
        m_busy = (m_stage.size() > 0) || m_pv;
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic drive(input bit v, input logic [BW-1:0] d, input bit fl, input bit full);
        bus.beat_valid = v; bus.beat_data = d; bus.flush_req = fl; bus.txfifo_full = full;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int idx, hit;
        logic [WW-1:0] w, got;
        bus.m_gen2_mode = 1'b1;
        drive(0, '0, 0, 0);
        for (int i = 0; i < 8; i++) ab[i] = rand_beat();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        sample();
        check("reset busy", WW'(bus.busy), '0);
        check("reset word_cnt", WW'(bus.word_cnt), '0);
        check("reset push", WW'(bus.txfifo_push), '0);
        tick();

        // 1: four back-to-back beats
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, ab[i], 0, 0);
            sample(); check("t1 ready", WW'(bus.beat_ready), WW'(1)); tick();
        end
        drive(0, '0, 0, 0);
        sample();
        check("t1 push", WW'(bus.txfifo_push), WW'(1));
        check("t1 data", bus.txfifo_downstream_data, {ab[3], ab[2], ab[1], ab[0]});
        tick();
        sample(); check("t1 word_cnt", WW'(bus.word_cnt), WW'(1)); tick();

        // 2: FIFO full backpressure
        do_reset();
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, ab[idx], 0, 1);
            sample(); if (last_acc) idx++; tick();
        end
        check("t2 accepted", WW'(idx), WW'(7));
        drive(1, ab[7], 0, 1);
        sample(); check("t2 stall ready", WW'(bus.beat_ready), '0); tick();
        drive(1, ab[7], 0, 0);
        sample();
        check("t2 push1", WW'(bus.txfifo_push), WW'(1));
        check("t2 data1", bus.txfifo_downstream_data, {ab[3], ab[2], ab[1], ab[0]});
        check("t2 ready8", WW'(bus.beat_ready), WW'(1));
        tick();
        drive(0, '0, 0, 0);
        sample();
        check("t2 push2", WW'(bus.txfifo_push), WW'(1));
        check("t2 data2", bus.txfifo_downstream_data, {ab[7], ab[6], ab[5], ab[4]});
        tick();
        sample(); check("t2 word_cnt", WW'(bus.word_cnt), WW'(2)); tick();

        // 3: flush of a one-beat word
        do_reset();
        drive(1, ab[0], 0, 0); step();
        drive(0, '0, 1, 0); step();
        drive(0, '0, 0, 0);
        w = '0; w[BW-1:0] = ab[0];
        sample();
        check("t3 push", WW'(bus.txfifo_push), WW'(1));
        check("t3 data", bus.txfifo_downstream_data, w);
        tick();

        // 4: idle timeout, then flush with empty staging
        do_reset();
        drive(1, ab[0], 0, 0); step();
        drive(1, ab[1], 0, 0); step();
        drive(0, '0, 0, 0);
        hit = 0; got = '0;
        for (int k = 1; k <= 20; k++) begin
            sample();
            if (hit == 0 && bus.txfifo_push) begin hit = k; got = bus.txfifo_downstream_data; end
            tick();
        end
        check("t4 timeout cycle", WW'(hit), WW'(9));
        w = '0; w[2*BW-1:0] = {ab[1], ab[0]};
        check("t4 data", got, w);
        drive(0, '0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            sample(); check("t4 empty flush", WW'(bus.txfifo_push), '0); tick();
        end
        drive(0, '0, 0, 0);

        // 5: gen1 two-slot words
        do_reset();
        bus.m_gen2_mode = 1'b0;
        drive(1, ab[2], 0, 0);
        sample(); check("t5 ready0", WW'(bus.beat_ready), WW'(1)); tick();
        drive(1, ab[3], 0, 0);
        sample(); check("t5 ready1", WW'(bus.beat_ready), WW'(1)); tick();
        drive(0, '0, 0, 0);
        sample();
        check("t5 push", WW'(bus.txfifo_push), WW'(1));
        w = '0; w[2*BW-1:0] = {ab[3], ab[2]};
        check("t5 data", bus.txfifo_downstream_data, w);
        check("t5 upper zero", WW'(bus.txfifo_downstream_data[WW-1:2*BW]), '0);
        tick();
        step();
        bus.m_gen2_mode = 1'b1;

        // 6: reset mid-word
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1, ab[i], 0, 0); step(); end
        rst_n = 1'b0;
        drive(1, ab[3], 0, 0);
        sample(); check("t6 ready in reset", WW'(bus.beat_ready), '0); tick();
        rst_n = 1'b1;
        drive(0, '0, 0, 0);
        sample();
        check("t6 busy", WW'(bus.busy), '0);
        check("t6 word_cnt", WW'(bus.word_cnt), '0);
        check("t6 push", WW'(bus.txfifo_push), '0);
        tick();
        for (int i = 4; i < 8; i++) begin drive(1, ab[i], 0, 0); step(); end
        drive(0, '0, 0, 0);
        sample();
        check("t6 data", bus.txfifo_downstream_data, {ab[7], ab[6], ab[5], ab[4]});
        tick();
        sample(); check("t6 word_cnt after", WW'(bus.word_cnt), WW'(1)); tick();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!m_busy && $urandom_range(0, 19) == 0) bus.m_gen2_mode = ~bus.m_gen2_mode;
            drive($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 19) == 0,
                  ((c / 40) % 2 == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2));
            if ((c / 300) % 3 == 2) bus.beat_valid = ($urandom_range(0, 9) < 2);
            step();
        end
        rst_n = 1'b1;
        drive(0, '0, 0, 0);
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
